// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and opcode classification for multicycle_alu.
// MULTICYCLE_ALU_DIV_EN adds DIVU/REMU to the iterative class.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_REMU = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Opcodes routed to the shift-add / restoring iterative unit.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef MULTICYCLE_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return op == OP_MUL;
`endif
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative unit: WIDTH-step shift-add multiplier and, with
// MULTICYCLE_ALU_DIV_EN, a restoring divider on the same registers.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
`ifdef MULTICYCLE_ALU_DIV_EN
  ,
  input  logic [3:0]       op,
  output logic             dbz
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // mul: x=accumulator, y=multiplicand, z=multiplier
  // div: x=partial remainder, y=dividend/quotient, z=divisor
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic [WIDTH-1:0] x_n, y_n, z_n;
`ifdef MULTICYCLE_ALU_DIV_EN
  logic [3:0]       mode_q;
  logic [WIDTH:0]   sh;
  logic             ge;
`endif

  // res is the value the final step produces, so the caller can register
  // it on the same edge that completes the last step.
  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    x_n = z_q[0] ? (x_q + y_q) : x_q;
    y_n = y_q << 1;
    z_n = z_q >> 1;
    res = x_n;
`ifdef MULTICYCLE_ALU_DIV_EN
    sh  = {x_q, y_q[WIDTH-1]};
    ge  = sh >= {1'b0, z_q};
    dbz = 1'b0;
    // With a zero divisor every step subtracts nothing, which naturally
    // yields an all-ones quotient and a remainder equal to the dividend.
    if (mode_q != OP_MUL) begin
      x_n = ge ? (sh[WIDTH-1:0] - z_q) : sh[WIDTH-1:0];
      y_n = {y_q[WIDTH-2:0], ge};
      z_n = z_q;
      res = (mode_q == OP_REMU) ? x_n : y_n;
      dbz = (z_q == '0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      mode_q <= OP_MUL;
`endif
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= a;
      z_q    <= b;
`ifdef MULTICYCLE_ALU_DIV_EN
      mode_q <= op;
`endif
    end else if (busy_q) begin
      x_q   <= x_n;
      y_q   <= y_n;
      z_q   <= z_n;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: handshake FSM, single-cycle ops and an iterative MUL/DIV unit.
// Define MULTICYCLE_ALU_DIV_EN to include the DIVU/REMU restoring divider.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t           state_q, state_n;
  logic             accept, iter_op, iter_start, iter_done;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] sum, dif, c_res;
  logic             c_ovf;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;

  assign accept     = in_valid && in_ready;
  assign iter_op    = is_iter_op(alu_op);
  assign iter_start = accept && iter_op;

`ifdef MULTICYCLE_ALU_DIV_EN
  logic iter_dbz, dbz_q;
`endif

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (iter_start),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .res   (iter_res)
`ifdef MULTICYCLE_ALU_DIV_EN
    ,
    .op    (alu_op),
    .dbz   (iter_dbz)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_n = iter_op ? S_BUSY : S_DONE;
      S_BUSY:  if (iter_done) state_n = S_DONE;
      S_DONE:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Single-cycle ops evaluate the live operands on the accepting edge.
  always_comb begin
    sum   = a + b;
    dif   = a - b;
    c_res = '0;
    c_ovf = 1'b0;
    case (alu_op)
      OP_AND:  c_res = a & b;
      OP_OR:   c_res = a | b;
      OP_ADD: begin
        c_res = sum;
        c_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        c_res = dif;
        c_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  c_res = ~(a | b);
      OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: c_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      dbz_q    <= 1'b0;
`endif
    end else if (accept && !iter_op) begin
      result_q <= c_res;
      ovf_q    <= c_ovf;
`ifdef MULTICYCLE_ALU_DIV_EN
      dbz_q    <= 1'b0;
`endif
    end else if (state_q == S_BUSY && iter_done) begin
      result_q <= iter_res;
      ovf_q    <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      dbz_q    <= iter_dbz;
`endif
    end
  end

  assign result   = result_q;
  assign zero     = (result_q == '0);
  assign overflow = ovf_q;
`ifdef MULTICYCLE_ALU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed plus randomized bench for multicycle_alu against an arithmetic
// reference model; follows MULTICYCLE_ALU_DIV_EN for DIVU/REMU expectations.
module tb_multicycle_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic         zero, overflow, div_by_zero;
  logic [3:0]   alu_op;
  logic [W-1:0] a, b, result;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on integers, latency in edges from accept.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic v, output logic dz, output int lat);
    longint sx, sy, s, lim;
    logic [63:0] p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lim = longint'(1) << (W - 1);
    r = '0; v = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin s = sx + sy; r = x + y; v = (s >= lim) || (s < -lim); end
      4'd3: begin s = sx - sy; r = x - y; v = (s >= lim) || (s < -lim); end
      4'd4: r = (sx < sy) ? 1 : 0;
      4'd5: r = ~(x | y);
      4'd6: r = (x < y) ? 1 : 0;
      4'd7: begin p = 64'(x) * 64'(y); r = p[W-1:0]; lat = W + 1; end
`ifdef MULTICYCLE_ALU_DIV_EN
      4'd8: begin r = (y == 0) ? '1 : x / y; dz = (y == 0); lat = W + 1; end
      4'd9: begin r = (y == 0) ? x : x % y; dz = (y == 0); lat = W + 1; end
`endif
      default: r = '0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int hold);
    logic [W-1:0] er;
    logic ev, ed, busy_rdy;
    int el, lat;
    model(op, x, y, er, ev, ed, el);
    @(negedge clk);
    chk($sformatf("%s.in_ready_idle", tag), in_ready, 1);
    in_valid = 1'b1; alu_op = op; a = x; b = y;
    @(negedge clk);
    lat = 1; busy_rdy = 1'b0;
    // Junk requests while busy must be ignored.
    while (!out_valid && lat < 100) begin
      busy_rdy |= in_ready;
      in_valid = 1'b1; alu_op = 4'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s.latency", tag), lat, el);
    chk($sformatf("%s.result", tag), result, er);
    chk($sformatf("%s.zero", tag), zero, (er == '0));
    chk($sformatf("%s.overflow", tag), overflow, ev);
    chk($sformatf("%s.div_by_zero", tag), div_by_zero, ed);
    if (el > 1) chk($sformatf("%s.in_ready_busy", tag), busy_rdy, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; alu_op = 4'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      chk($sformatf("%s.hold_result", tag), result, er);
      chk($sformatf("%s.hold_out_valid", tag), out_valid, 1);
      chk($sformatf("%s.hold_in_ready", tag), in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s.out_valid_drop", tag), out_valid, 0);
    chk($sformatf("%s.in_ready_back", tag), in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.zero", zero, 1);
    chk("rst.overflow", overflow, 0);
    chk("rst.div_by_zero", div_by_zero, 0);
    reset = 1'b0;

    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 0);
    run_op("slt", 4'd4, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("mul", 4'd7, 32'h0001_0001, 32'h0001_0001, 0);
    run_op("divu", 4'd8, 32'd100, 32'd7, 0);
    run_op("remu", 4'd9, 32'd100, 32'd7, 0);
    run_op("divu_z", 4'd8, 32'd5, 32'd0, 0);
    run_op("remu_z", 4'd9, 32'd5, 32'd0, 0);
    run_op("hold_and", 4'd0, 32'hF0F0_1234, 32'hFF00_FF0F, 5);
    run_op("unknown", 4'd12, 32'h1234_5678, 32'h9, 0);
    run_op("sub_ovf", 4'd3, 32'h8000_0000, 32'h1, 0);
    run_op("nor", 4'd5, 32'h0F0F_0000, 32'h0000_00F0, 0);
    run_op("add_pre", 4'd2, 32'd1, 32'd1, 0);

    // Reset during BUSY cycle 10 of a MUL aborts it.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'd7; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_in_ready", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.in_ready", in_ready, 1);
    chk("abort.out_valid", out_valid, 0);
    chk("abort.result", result, 0);
    chk("abort.zero", zero, 1);
    repeat (40) @(negedge clk);
    chk("abort.no_late_valid", out_valid, 0);
    run_op("sub_zero", 4'd3, 32'd3, 32'd3, 0);

    // Reset wins over a same-cycle acceptance.
    in_valid = 1'b1; alu_op = 4'd2; a = 32'd1; b = 32'd1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("rstpri.in_ready", in_ready, 1);
    @(negedge clk);
    chk("rstpri.out_valid", out_valid, 0);

    for (int n = 0; n < 30; n++) begin
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 4'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_op($sformatf("rnd%0d", n), rop, ra, rb, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width (legal range 4..64).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  operation request.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port alu_op  input  4  opcode: AND=0, OR=1, ADD=2, SUB=3, SLT=4 (signed), NOR=5, SLTU=6, MUL=7 (low WIDTH bits), DIVU=8, REMU=9.
REQ-008 Port a, b  input  WIDTH  operands.
REQ-009 Port out_valid  output  1  result valid.
REQ-010 Port out_ready  input  1  consumer takes result.
REQ-011 Port result  output  WIDTH  registered result.
REQ-012 Port zero  output  1  result equals 0.
REQ-013 Port overflow  output  1  signed overflow, ADD/SUB only.
REQ-014 Port div_by_zero  output  1  DIVU/REMU issued with b=0.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE, with in_ready=1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where in_valid && in_ready, capturing alu_op, a and b.
REQ-017 Single-cycle ops (0-6, and unknown opcodes) SHALL go IDLE->DONE, with out_valid=1 in the cycle after acceptance.
REQ-018 MUL SHALL go IDLE->BUSY, perform one shift-add step per cycle for WIDTH cycles, then enter DONE, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 DIVU/REMU SHALL use a restoring divider with the same WIDTH-step timing as MUL.
REQ-020 On division by zero, DIVU SHALL return all ones and REMU SHALL return a, with div_by_zero=1 and the same latency as a normal divide.
REQ-021 The FSM SHALL hold DONE, with result and flags stable, until out_ready=1; it SHALL then return to IDLE.
REQ-022 in_ready SHALL be 0 in DONE, so there is no same-cycle re-accept and the maximum throughput is one op per 2 cycles.
REQ-023 ADD/SUB SHALL be modulo 2^WIDTH, with overflow set when the operand signs make the sign of the result invalid; overflow SHALL be 0 for all other ops.
REQ-024 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH.
REQ-025 Unknown opcodes SHALL return result=0, zero=1, with no error flag.
REQ-026 zero SHALL be derived from the registered result and SHALL be valid whenever out_valid=1.
REQ-027 in_valid SHALL be ignored outside IDLE, and a, b and alu_op may change freely during BUSY.

Reset
REQ-028 Reset SHALL force state=IDLE, out_valid=0, result=0, zero=1, overflow=0, div_by_zero=0 and in_ready=1 on the next edge.
REQ-029 Reset asserted during BUSY or DONE SHALL abort the operation and discard the result; reset SHALL take priority over an acceptance in the same cycle.

Configuration
REQ-030 The block SHALL support the macro MULTICYCLE_ALU_DIV_EN.
REQ-031 With MULTICYCLE_ALU_DIV_EN defined, the divider SHALL be present and DIVU/REMU SHALL behave per REQ-019 and REQ-020.
REQ-032 Without MULTICYCLE_ALU_DIV_EN, opcodes 8/9 SHALL be treated as unknown per REQ-025 (1-cycle latency), div_by_zero SHALL be tied 0, and no divider logic SHALL be generated.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode localparams, the FSM state encoding and the single-cycle/iterative opcode classification function.
REQ-034 Sub-module alu_iter_unit SHALL implement the shared iterative shift-add multiplier and restoring divider (start, step counter, done), and multicycle_alu SHALL hold the FSM, the handshake and the combinational ops.

Verification
REQ-035 Bench SHALL cover: WIDTH=32, ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
REQ-036 Bench SHALL cover: SLT a=0xFFFFFFFF b=1 -> 1; SLTU with the same operands -> 0.
REQ-037 Bench SHALL cover: MUL a=0x10001 b=0x10001 -> 0x00020001, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-038 Bench SHALL cover: with the macro defined, DIVU 100/7 -> 14 and REMU -> 2; DIVU 5/0 -> 0xFFFFFFFF with div_by_zero=1; without the macro, DIVU -> 0 with zero=1 after 1 cycle.
REQ-039 Bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0, and a new in_valid ignored.
REQ-040 Bench SHALL cover: reset at BUSY cycle 10 of MUL -> next cycle state IDLE, out_valid=0, result=0, and a new SUB 3-3 then returns 0 with zero=1.
